// File: rtl/hdr_merge_if.sv
// hdr_merge_if: input/output valid-ready bundle for the HDR merge stage.
`default_nettype none

interface hdr_merge_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] pixel_high;
  logic [N-1:0] pixel_mid;
  logic [N-1:0] pixel_low;
  logic [7:0]   w_high;
  logic [7:0]   w_mid;
  logic [7:0]   w_low;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] pix_out;

  modport master (
    output in_valid, pixel_high, pixel_mid, pixel_low, w_high, w_mid, w_low, out_ready,
    input  in_ready, out_valid, pix_out
  );

  modport slave (
    input  in_valid, pixel_high, pixel_mid, pixel_low, w_high, w_mid, w_low, out_ready,
    output in_ready, out_valid, pix_out
  );
endinterface

`default_nettype wire

// File: rtl/hdr_merge.sv
// ============================================================================
// hdr_merge: weighted average of three exposures via a restoring divider.
// Option macro: HDR_MERGE_ROUND_EN (round-to-nearest instead of floor).
// Rev 1.0
// ============================================================================
`default_nettype none

module hdr_merge #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  hdr_merge_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_ph, r_pm, r_pl;
  logic [7:0]     r_wh, r_wm, r_wl;
  logic [10:0]    r_rem;
  logic [N-1:0]   r_shift;
  logic [CW-1:0]  r_cnt;
  logic           r_sat;
  logic [N-1:0]   r_pix;
  logic           r_ovalid;

  logic [N+9:0]   w_num;
  logic [N+9:0]   w_num_adj;
  logic [9:0]     w_den;
  logic [11:0]    w_trial;
  logic [10:0]    w_sub;
  logic           w_qbit;

  assign w_num = ({{(N+2){1'b0}}, r_wh} * {10'd0, r_ph})
               + ({{(N+2){1'b0}}, r_wm} * {10'd0, r_pm})
               + ({{(N+2){1'b0}}, r_wl} * {10'd0, r_pl});
  assign w_den = {2'b00, r_wh} + {2'b00, r_wm} + {2'b00, r_wl};

`ifdef HDR_MERGE_ROUND_EN
  assign w_num_adj = w_num + {{(N+1){1'b0}}, w_den[9:1]};
`else
  assign w_num_adj = w_num;
`endif

  // Trial fits 11 bits whenever it is >= den, since rem < den <= 765.
  assign w_trial = {r_rem, r_shift[N-1]};
  assign w_qbit  = (w_trial >= {2'b00, w_den});
  assign w_sub   = w_trial[10:0] - {1'b0, w_den};

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_ovalid;
  assign bus.pix_out   = r_pix;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid)        w_state_nxt = S_MUL;
      S_MUL:  w_state_nxt = (w_den == 10'd0) ? S_DONE : S_DIV;
      S_DIV:  if (r_cnt == '0)         w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready)       w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ph     <= '0;
      r_pm     <= '0;
      r_pl     <= '0;
      r_wh     <= '0;
      r_wm     <= '0;
      r_wl     <= '0;
      r_rem    <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_pix    <= '0;
      r_ovalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_ph <= bus.pixel_high;
            r_pm <= bus.pixel_mid;
            r_pl <= bus.pixel_low;
            r_wh <= bus.w_high;
            r_wm <= bus.w_mid;
            r_wl <= bus.w_low;
          end
        end
        S_MUL: begin
          if (w_den == 10'd0) begin
            r_pix    <= r_pm;
            r_ovalid <= 1'b1;
          end else begin
            r_rem   <= {1'b0, w_num_adj[N+9:N]};
            r_shift <= w_num_adj[N-1:0];
            r_cnt   <= CW'(N-1);
            // Upper part already >= den would mean a quotient wider than N bits.
            r_sat   <= (w_num_adj[N+9:N] >= w_den);
          end
        end
        S_DIV: begin
          r_rem   <= w_qbit ? w_sub : w_trial[10:0];
          r_shift <= {r_shift[N-2:0], w_qbit};
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_pix    <= r_sat ? {N{1'b1}} : {r_shift[N-2:0], w_qbit};
            r_ovalid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_ovalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: doc/hdr_merge.md
# hdr_merge

Per-pixel HDR merge stage sitting directly downstream of the weight generator. Accepts the three exposure pixels (high/mid/low) and their 8-bit triangle weights, and computes the weighted average Σ(wᵢ·pᵢ)/Σwᵢ with a multi-cycle restoring divider. Produces one N-bit merged pixel per transaction over a valid/ready handshake on both sides.

## Interface
- N, default 8: pixel width in bits; must be ≥ 2.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input; high only in IDLE.
- pixel_high / pixel_mid / pixel_low  in  N each  exposure pixels, time-aligned with the weights.
- w_high / w_mid / w_low  in  8 each  weights from the weight stage, unsigned.
- out_valid  out  1  merged pixel valid; held until accepted.
- out_ready  in  1  downstream accepts pix_out.
- pix_out  out  N  merged pixel.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset → IDLE, in_ready=1, out_valid=0, pix_out=0, all internal registers 0.
- IDLE: on in_valid & in_ready, register all six inputs and go to MUL. Otherwise stay.
- MUL (1 cycle):
  - num = w_high·pixel_high + w_mid·pixel_mid + w_low·pixel_low, width N+10, unsigned, no truncation.
  - den = w_high + w_mid + w_low, width 10.
  - If den == 0: pix_out ← registered pixel_mid, go to DONE (divider bypassed).
  - Else: rem ← num >> N (width 11; guaranteed < den); shift register ← num[N-1:0]; count ← N-1; go to DIV.
- DIV (exactly N cycles, restoring, one quotient bit per cycle, MSB first):
  - trial = {rem, next num bit}; if trial ≥ den then rem ← trial − den and the quotient bit is 1, else rem ← trial and the bit is 0.
  - After the N-th iteration: pix_out ← quotient, go to DONE.
- Quotient is always ≤ max input pixel ≤ 2^N−1. If it would exceed 2^N−1, pix_out saturates to 2^N−1 as a defensive measure.
- DONE: out_valid=1, pix_out stable. On out_ready: out_valid ← 0, go to IDLE.
- in_ready = (state == IDLE). No input is accepted during MUL/DIV/DONE. in_valid outside IDLE is ignored.
- Reset asserted in any state: the in-flight transaction is discarded and all outputs take their reset values on the next edge.

## Timing
- Acceptance edge E0. MUL executes at E1. DIV executes at E2…E(N+1). out_valid rises after E(N+1), giving latency N+1 cycles from acceptance (9 for N=8).
- den == 0 path: out_valid rises after E1, giving latency 1.
- If out_ready is already high when out_valid rises, the handshake completes at the next edge. The state is IDLE (in_ready=1) one cycle later.
- Minimum transaction period is N+3 cycles.
- out_valid and pix_out are registered. in_ready is a decode of the state register only, with no combinational path from any input.

## Configuration
- HDR_MERGE_ROUND_EN defined: in MUL, num ← num + (den >> 1) before loading the divider, giving round-to-nearest with ties rounded up. The saturation guard still applies.
- Not defined: truncating division (floor).
- Latency is identical in both builds.

## Test plan
- N=8, pixels 10/20/30, weights 1/1/1, out_ready=1 → pix_out=20, out_valid 9 cycles after acceptance, held for 1 cycle.
- Pixels 100/50/0, weights 1/2/1 → num=200, den=4, pix_out=50.
- Pixels 1/2/2, weights 1/1/1 → pix_out=1 without HDR_MERGE_ROUND_EN, 2 with it.
- Weights 0/0/0, pixel_mid=77 → pix_out=77 with out_valid after 1 cycle. Pixels 255/255/255, weights 255/255/255 → pix_out=255 with no overflow.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → pix_out and out_valid stay constant and in_ready stays 0. A second in_valid pulse during DIV is not accepted.
- Assert rst_n=0 for one cycle at the 4th DIV cycle → next cycle out_valid=0, pix_out=0, in_ready=1. A new transaction (10/20/30, 1/1/1) then yields 20.
